// File: rtl/ax_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ax_probe_pkg
//  Description : Shared types and constants for the approximate-circuit
//                truth-table probe (FSM state encoding, parameter defaults
//                and legal limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package ax_probe_pkg;

    // Input count: defaults and legal range
    localparam int c_n_in_def    = 6;
    localparam int c_n_in_min    = 1;
    localparam int c_n_in_max    = 8;

    // Latency of the circuit under test: defaults and legal range
    localparam int c_dut_lat_def = 0;
    localparam int c_dut_lat_min = 0;
    localparam int c_dut_lat_max = 7;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } probe_state_t;

endpackage : ax_probe_pkg
`default_nettype wire

// File: rtl/ax_probe_dly.sv
`default_nettype none
// ============================================================================
//  Module      : ax_probe_dly
//  Description : Valid/index delay line that aligns issued patterns with the
//                response of a pipelined circuit under test. LAT register
//                stages; a plain wire when LAT is 0. Cleared by rst or flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module ax_probe_dly #(
    parameter int LAT = 0,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_vld,
    input  logic [W-1:0] i_idx,
    output logic         o_vld,
    output logic [W-1:0] o_idx
);

    if (LAT == 0) begin : g_pass
        // No storage: clock, reset and flush have nothing to act on
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst, i_flush};
        assign o_vld    = i_vld;
        assign o_idx    = i_idx;
    end else begin : g_pipe
        logic [LAT-1:0]        r_vld;
        logic [LAT-1:0][W-1:0] r_idx;

        // Shift valid and index one stage per cycle; clear everything on flush
        always_ff @(posedge clk) begin
            if (rst || i_flush) begin
                r_vld <= '0;
                r_idx <= '0;
            end else begin
                r_vld[0] <= i_vld;
                r_idx[0] <= i_idx;
                for (int s = 1; s < LAT; s++) begin
                    r_vld[s] <= r_vld[s-1];
                    r_idx[s] <= r_idx[s-1];
                end
            end
        end

        assign o_vld = r_vld[LAT-1];
        assign o_idx = r_idx[LAT-1];
    end

endmodule : ax_probe_dly
`default_nettype wire

// File: rtl/ax_tt_probe.sv
`default_nettype none
// ============================================================================
//  Module      : ax_tt_probe
//  Description : Sweeps all 2**N_IN input patterns through an approximate
//                circuit, captures its truth table and counts the Hamming
//                distance to a golden truth table.
//                Optional feature macro: AX_PROBE_ERRMAP_EN adds the err_map
//                output (per-pattern error bitmap).
//  Revision    : 1.0 - initial release
// ============================================================================
module ax_tt_probe
    import ax_probe_pkg::*;
#(
    parameter int  N_IN    = c_n_in_def,
    parameter int  DUT_LAT = c_dut_lat_def,
    localparam int TT      = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT-1:0]   golden_tt,
    output logic [N_IN-1:0] dut_pi,
    input  logic            dut_po,
    output logic            busy,
    output logic            done,
    output logic [TT-1:0]   tt_out,
    output logic [N_IN:0]   err_cnt
`ifdef AX_PROBE_ERRMAP_EN
    ,
    output logic [TT-1:0]   err_map
`endif
);

    localparam logic [N_IN-1:0] c_last_idx = {N_IN{1'b1}};
    localparam logic [N_IN:0]   c_err_max  = {1'b1, {N_IN{1'b0}}};

    probe_state_t    r_state;
    logic            r_busy;
    logic            r_done;
    logic [N_IN-1:0] r_pi;
    logic [TT-1:0]   r_golden;
    logic [TT-1:0]   r_tt;
    logic [N_IN:0]   r_err;

    logic            w_start_acc;
    logic            w_iss_vld;
    logic            w_dly_vld;
    logic [N_IN-1:0] w_dly_idx;
    logic            w_cap;
    logic            w_mis;

    // A start is honoured only from IDLE and only if abort is not also asserted
    assign w_start_acc = (r_state == ST_IDLE) && start && !abort;
    assign w_iss_vld   = (r_state == ST_RUN);
    assign w_cap       = w_dly_vld && !abort;
    assign w_mis       = dut_po ^ r_golden[w_dly_idx];

    ax_probe_dly #(
        .LAT (DUT_LAT),
        .W   (N_IN)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_vld   (w_iss_vld),
        .i_idx   (r_pi),
        .o_vld   (w_dly_vld),
        .o_idx   (w_dly_idx)
    );

    // Sweep controller with registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_acc) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_pi == c_last_idx) begin
                        // Combinational DUT: the last capture happens now
                        if (DUT_LAT == 0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_dly_vld && (w_dly_idx == c_last_idx)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Pattern generator: counts 0..TT-1 while running, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pi <= '0;
        end else if (w_start_acc) begin
            r_pi <= '0;
        end else if ((r_state == ST_RUN) && !abort && (r_pi != c_last_idx)) begin
            r_pi <= r_pi + 1'b1;
        end
    end

    // Golden snapshot, truth-table capture and saturating error count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_golden <= '0;
            r_tt     <= '0;
            r_err    <= '0;
        end else if (w_start_acc) begin
            r_golden <= golden_tt;
            r_tt     <= '0;
            r_err    <= '0;
        end else if (w_cap) begin
            r_tt[w_dly_idx] <= dut_po;
            if (w_mis && (r_err != c_err_max)) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

`ifdef AX_PROBE_ERRMAP_EN
    logic [TT-1:0] r_err_map;

    // Per-pattern mismatch bitmap, built alongside the capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_map <= '0;
        end else if (w_start_acc) begin
            r_err_map <= '0;
        end else if (w_cap) begin
            r_err_map[w_dly_idx] <= w_mis;
        end
    end

    assign err_map = r_err_map;
`endif

    assign dut_pi  = r_pi;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tt_out  = r_tt;
    assign err_cnt = r_err;

endmodule : ax_tt_probe
`default_nettype wire
